// File: rtl/alu_key_sequencer_if.sv
// Key/switch inputs and strobe/capture outputs of the ALU key sequencer.
// master = stimulus/consumer side, slave = the sequencer itself.
interface alu_key_sequencer_if #(
  parameter int unsigned IN_W = 2,
  parameter int unsigned OP_W = 4
);
  logic            key_a;
  logic            key_b;
  logic            key_f;
  logic [IN_W-1:0] in_sw;
  logic [OP_W-1:0] op_sw;
  logic            ld_a;
  logic            ld_b;
  logic            ld_f;
  logic [IN_W-1:0] in_q;
  logic [OP_W-1:0] op_q;
  logic [1:0]      state;
  logic            err;

  modport master (
    output key_a, key_b, key_f, in_sw, op_sw,
    input  ld_a, ld_b, ld_f, in_q, op_q, state, err
  );

  modport slave (
    input  key_a, key_b, key_f, in_sw, op_sw,
    output ld_a, ld_b, ld_f, in_q, op_q, state, err
  );
endinterface

// File: rtl/alu_key_sequencer.sv
// Debounces three push-buttons into single-cycle A/B/F load strobes and enforces A->B->F order.
// Optional macro SEQ_ORDER_EN: when defined, out-of-order presses are rejected with err.
module alu_key_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned IN_W            = 2,
  parameter int unsigned OP_W            = 4
) (
  input logic               clk,
  input logic               rst_n,
  alu_key_sequencer_if.slave bus
);
  localparam int unsigned NK       = 3;
  localparam int unsigned CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_A_OK = 2'd1,
    S_B_OK = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Key vectors: bit 2 = A, bit 1 = B, bit 0 = F
  logic [NK-1:0]    key_raw;
  logic [NK-1:0]    sync1_q, sync2_q;
  logic [NK-1:0]    stable_q, stable_d, stable_dly_q;
  logic [NK-1:0]    press_c;
  logic [CNT_W-1:0] cnt_q [NK];
  logic [CNT_W-1:0] cnt_d [NK];

  state_e           state_q, state_d;
  logic             ld_a_q, ld_a_d, ld_b_q, ld_b_d, ld_f_q, ld_f_d, err_q, err_d;
  logic [IN_W-1:0]  in_cap_q, in_cap_d;
  logic [OP_W-1:0]  op_cap_q, op_cap_d;
  logic             ok_b, ok_f;

  assign key_raw = {bus.key_a, bus.key_b, bus.key_f};
  assign press_c = stable_q & ~stable_dly_q;

  // Synchronizers, debounce counters and stable levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      for (int k = 0; k < NK; k++) cnt_q[k] <= '0;
    end else begin
      sync1_q      <= key_raw;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      for (int k = 0; k < NK; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  always_comb begin
    stable_d = stable_q;
    for (int k = 0; k < NK; k++) begin
      cnt_d[k] = '0;
      if (sync2_q[k] != stable_q[k]) begin
        if (cnt_q[k] == CNT_LAST) stable_d[k] = sync2_q[k];
        else                      cnt_d[k]    = cnt_q[k] + CNT_W'(1);
      end
    end
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ld_a_q   <= 1'b0;
      ld_b_q   <= 1'b0;
      ld_f_q   <= 1'b0;
      err_q    <= 1'b0;
      in_cap_q <= '0;
      op_cap_q <= '0;
    end else begin
      state_q  <= state_d;
      ld_a_q   <= ld_a_d;
      ld_b_q   <= ld_b_d;
      ld_f_q   <= ld_f_d;
      err_q    <= err_d;
      in_cap_q <= in_cap_d;
      op_cap_q <= op_cap_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ld_a_d   = 1'b0;
    ld_b_d   = 1'b0;
    ld_f_d   = 1'b0;
    in_cap_d = in_cap_q;
    op_cap_d = op_cap_q;
`ifdef SEQ_ORDER_EN
    ok_b     = (state_q == S_A_OK) || (state_q == S_B_OK);
    ok_f     = (state_q == S_B_OK) || (state_q == S_DONE);
`else
    ok_b     = 1'b1;
    ok_f     = 1'b1;
`endif
    // Any second simultaneous press is a discarded loser
    err_d    = (press_c[2] & (press_c[1] | press_c[0])) | (press_c[1] & press_c[0]);

    if (press_c[2]) begin
      ld_a_d   = 1'b1;
      in_cap_d = bus.in_sw;
      state_d  = S_A_OK;
    end else if (press_c[1]) begin
      if (ok_b) begin
        ld_b_d   = 1'b1;
        in_cap_d = bus.in_sw;
        state_d  = S_B_OK;
      end else begin
        err_d = 1'b1;
      end
    end else if (press_c[0]) begin
      if (ok_f) begin
        ld_f_d   = 1'b1;
        op_cap_d = bus.op_sw;
        state_d  = S_DONE;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  assign bus.ld_a  = ld_a_q;
  assign bus.ld_b  = ld_b_q;
  assign bus.ld_f  = ld_f_q;
  assign bus.err   = err_q;
  assign bus.in_q  = in_cap_q;
  assign bus.op_q  = op_cap_q;
  assign bus.state = 2'(state_q);
endmodule

// File: tb/tb_alu_key_sequencer.sv
// Scoreboard bench for alu_key_sequencer with DEBOUNCE_CYCLES=4; honours SEQ_ORDER_EN.
module tb_alu_key_sequencer;
  localparam int unsigned DB   = 4;
  localparam int unsigned IN_W = 2;
  localparam int unsigned OP_W = 4;
`ifdef SEQ_ORDER_EN
  localparam bit ORDERED = 1'b1;
`else
  localparam bit ORDERED = 1'b0;
`endif

  typedef struct packed {
    logic            ld_a;
    logic            ld_b;
    logic            ld_f;
    logic            err;
    logic [IN_W-1:0] in_q;
    logic [OP_W-1:0] op_q;
    logic [1:0]      state;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t obs;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc;
  exp_t sb[$];

  logic [1:0]      m_state;
  logic [IN_W-1:0] m_in;
  logic [OP_W-1:0] m_op;

  always #5 clk = ~clk;

  alu_key_sequencer_if #(.IN_W(IN_W), .OP_W(OP_W)) bus ();

  alu_key_sequencer #(.DEBOUNCE_CYCLES(DB), .IN_W(IN_W), .OP_W(OP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Edge counter: value N after the Nth rising edge following reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic obs_t sample();
    obs_t o;
    o.ld_a  = bus.ld_a;
    o.ld_b  = bus.ld_b;
    o.ld_f  = bus.ld_f;
    o.err   = bus.err;
    o.in_q  = bus.in_q;
    o.op_q  = bus.op_q;
    o.state = bus.state;
    return o;
  endfunction

  // Monitor: every strobe/err cycle must match the head of the scoreboard
  obs_t mon_got;
  exp_t mon_exp;
  always @(negedge clk) begin
    if (rst_n && (bus.ld_a || bus.ld_b || bus.ld_f || bus.err)) begin
      mon_got = sample();
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event got=%h cyc=%0d", mon_got, cyc);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_got !== mon_exp.obs || cyc != mon_exp.cyc) begin
          bad++;
          $display("FAIL event got=%h@%0d exp=%h@%0d", mon_got, cyc, mon_exp.obs, mon_exp.cyc);
        end
      end
    end
  end

  task automatic check_idle(input string name);
    obs_t got;
    obs_t exp;
    got = sample();
    exp = '0;
    exp.in_q  = m_in;
    exp.op_q  = m_op;
    exp.state = m_state;
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference behaviour for a press beginning on the next rising edge
  task automatic expect_press(input logic [2:0] mask);
    exp_t e;
    logic la, lb, lf, er;
    la = 1'b0; lb = 1'b0; lf = 1'b0;
    er = ($countones(mask) > 1);
    if (mask[2]) begin
      la = 1'b1; m_in = bus.in_sw; m_state = 2'd1;
    end else if (mask[1]) begin
      if (!ORDERED || m_state == 2'd1 || m_state == 2'd2) begin
        lb = 1'b1; m_in = bus.in_sw; m_state = 2'd2;
      end else er = 1'b1;
    end else if (mask[0]) begin
      if (!ORDERED || m_state == 2'd2 || m_state == 2'd3) begin
        lf = 1'b1; m_op = bus.op_sw; m_state = 2'd3;
      end else er = 1'b1;
    end
    e.cyc = cyc + 1 + DB + 2;
    e.obs = {la, lb, lf, er, m_in, m_op, m_state};
    if (la || lb || lf || er) sb.push_back(e);
  endtask

  task automatic press(input logic [2:0] mask, input string name);
    @(negedge clk);
    {bus.key_a, bus.key_b, bus.key_f} = mask;
    expect_press(mask);
    repeat (DB + 4) @(negedge clk);
    {bus.key_a, bus.key_b, bus.key_f} = 3'b000;
    repeat (DB + 6) @(negedge clk);
    check_idle(name);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    {bus.key_a, bus.key_b, bus.key_f} = 3'b000;
    repeat (2) @(negedge clk);
    m_state = 2'd0; m_in = '0; m_op = '0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("after_reset");
  endtask

  initial begin
    m_state = 2'd0; m_in = '0; m_op = '0;
    bus.key_a = 1'b1; bus.key_b = 1'b1; bus.key_f = 1'b1;
    bus.in_sw = 2'b10; bus.op_sw = 4'b0000;

    // Reset with keys high, then release holding key_a
    repeat (3) @(negedge clk);
    check_idle("reset_outputs");
    bus.key_b = 1'b0; bus.key_f = 1'b0;
    rst_n = 1'b1;
    expect_press(3'b100);
    repeat (DB + 6) @(negedge clk);
    bus.key_a = 1'b0;
    repeat (DB + 6) @(negedge clk);
    check_idle("reset_held_a");

    // Short glitch must be ignored
    @(negedge clk); bus.key_a = 1'b1;
    repeat (3) @(negedge clk);
    bus.key_a = 1'b0;
    repeat (DB + 8) @(negedge clk);
    check_idle("glitch");

    // Bounce 1,0,1,0 then hold -> one ld_a (reload)
    bus.in_sw = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.key_a = (i % 2 == 0);
    end
    press(3'b100, "bounce");

    // Out-of-order F from IDLE
    do_reset();
    bus.op_sw = 4'b1111;
    press(3'b001, "f_from_idle");

    // Normal A -> B -> F sequence
    do_reset();
    bus.in_sw = 2'b01; press(3'b100, "seq_a");
    bus.in_sw = 2'b00; press(3'b010, "seq_b");
    bus.op_sw = 4'b0100; press(3'b001, "seq_f");

    // B in DONE, then recompute with new opcode
    bus.in_sw = 2'b11; press(3'b010, "b_in_done");
    bus.op_sw = 4'b1010; press(3'b001, "f_recompute");

    // Simultaneous presses
    bus.in_sw = 2'b10; press(3'b100, "a_again");
    bus.in_sw = 2'b01; press(3'b110, "sim_ab");
    bus.in_sw = 2'b11; press(3'b111, "sim_abf");
    bus.in_sw = 2'b00; bus.op_sw = 4'b0011; press(3'b011, "sim_bf");
    bus.op_sw = 4'b0110; press(3'b001, "f_in_b_ok");

    // All expected events must have been observed
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL pending_events got=%0d exp=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
